// File: rtl/ac_writeback_seq.sv
// Sequencing and writeback stage for the 8-bit accumulator datapath.
// Holds the latched opcode steady toward the output mux for SETTLE_CYCLES
// cycles so the gate-level ALU/mux can settle. It then commits the mux
// result and the Z/N/C flags, and pulses done for one cycle.
module ac_writeback_seq #(
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned WIDTH         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             acc_load,
    input  logic [WIDTH-1:0] acc_load_val,
    input  logic [WIDTH-1:0] result,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             carry_in,
    input  logic             shift_co,
    output logic [2:0]       op_hold,
    output logic [WIDTH-1:0] acc,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StSettle, StCommit} state_t;

    localparam logic [2:0] OpAdd   = 3'b100;
    localparam logic [2:0] OpSub   = 3'b101;
    localparam logic [2:0] OpShift = 3'b110;
    localparam logic [2:0] OpCmp   = 3'b111;

    // The counter is loaded with SETTLE_CYCLES-1 so that the SETTLE state
    // lasts exactly SETTLE_CYCLES cycles, including the cycle where cnt == 0.
    localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;

    // Sequencer FSM with registered outputs; busy tracks the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= StIdle;
            cnt     <= 4'd0;
            op_hold <= 3'b000;
            acc     <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_c  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    // start wins over acc_load; a simultaneous load is dropped
                    if (start) begin
                        op_hold <= op;
                        cnt     <= CntInit;
                        busy    <= 1'b1;
                        state   <= StSettle;
                    end else if (acc_load) begin
                        acc <= acc_load_val;
                    end
                end
                StSettle: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= StCommit;
                    end
                end
                StCommit: begin
                    if (op_hold == OpCmp) begin
                        // cmp updates only the flags, from the raw adder output
                        flag_z <= (sum_in == '0);
                        flag_n <= sum_in[WIDTH-1];
                        flag_c <= carry_in;
                    end else begin
                        acc    <= result;
                        flag_z <= (result == '0);
                        flag_n <= result[WIDTH-1];
                        unique case (op_hold)
                            OpAdd, OpSub: flag_c <= carry_in;
                            OpShift:      flag_c <= shift_co;
                            default:      flag_c <= 1'b0;
                        endcase
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ac_writeback_seq.sv
// Directed self-checking bench for ac_writeback_seq. Expected commits are
// queued when an operation is accepted and then checked on each done pulse.
module tb_ac_writeback_seq;

    localparam int unsigned S = 3;

    typedef struct packed {
        logic [7:0] acc;
        logic       z;
        logic       n;
        logic       c;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic       acc_load = 1'b0;
    logic [7:0] acc_load_val = 8'h00;
    logic [7:0] result = 8'h00;
    logic [7:0] sum_in = 8'h00;
    logic       carry_in = 1'b0;
    logic       shift_co = 1'b0;
    logic [2:0] op_hold;
    logic [7:0] acc;
    logic       flag_z, flag_n, flag_c, busy, done;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;
    exp_t sb[$];
    logic [7:0] model_acc = 8'h00;

    ac_writeback_seq #(.SETTLE_CYCLES(S), .WIDTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .op           (op),
        .acc_load     (acc_load),
        .acc_load_val (acc_load_val),
        .result       (result),
        .sum_in       (sum_in),
        .carry_in     (carry_in),
        .shift_co     (shift_co),
        .op_hold      (op_hold),
        .acc          (acc),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .flag_c       (flag_c),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected commit outcome, written directly from the opcode table.
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] res,
                                   input logic [7:0] sum, input logic cy,
                                   input logic sh, input logic [7:0] acc_before);
        exp_t e;
        if (o == 3'b111) begin
            e.acc = acc_before;
            e.z   = (sum == 8'h00);
            e.n   = sum[7];
            e.c   = cy;
        end else begin
            e.acc = res;
            e.z   = (res == 8'h00);
            e.n   = res[7];
            e.c   = (o == 3'b100 || o == 3'b101) ? cy : (o == 3'b110) ? sh : 1'b0;
        end
        return e;
    endfunction

    // Advance to the next falling edge and score any done pulse there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("commit_acc", 32'(acc), 32'(e.acc));
                chk("commit_z", 32'(flag_z), 32'(e.z));
                chk("commit_n", 32'(flag_n), 32'(e.n));
                chk("commit_c", 32'(flag_c), 32'(e.c));
                chk("done_busy_low", 32'(busy), 32'(0));
            end
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [7:0] res, input logic [7:0] sum,
                          input logic cy, input logic sh, input logic also_load);
        exp_t e;
        int   d0;
        int   k;
        op = o; result = res; sum_in = sum; carry_in = cy; shift_co = sh;
        start = 1'b1; acc_load = also_load; acc_load_val = 8'hA5;
        e = model(o, res, sum, cy, sh, model_acc);
        sb.push_back(e);
        model_acc = e.acc;
        d0 = n_done;
        tick();
        start = 1'b0; acc_load = 1'b0;
        chk("accept_op_hold", 32'(op_hold), 32'(o));
        chk("accept_busy", 32'(busy), 32'(1));
        k = 0;
        while (n_done == d0 && k < 20) begin
            tick();
            k++;
            if (n_done == d0) chk("settle_busy", 32'(busy), 32'(1));
        end
        chk("done_seen", 32'(n_done - d0), 32'(1));
        chk("latency", 32'(k), 32'(S + 1));
        tick();
        chk("done_one_cycle", 32'(done), 32'(0));
    endtask

    initial begin
        logic [2:0] exp_hold;
        logic [2:0] nxt_op;
        int         d0;

        // Reset values
        tick(); tick();
        chk("rst_acc", 32'(acc), 32'(0));
        chk("rst_op_hold", 32'(op_hold), 32'(0));
        chk("rst_flags", 32'({flag_z, flag_n, flag_c}), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        reset_n = 1'b1;
        tick();

        // Direct accumulator load in IDLE
        acc_load = 1'b1; acc_load_val = 8'h5A;
        tick();
        acc_load = 1'b0;
        model_acc = 8'h5A;
        chk("load_acc", 32'(acc), 32'(8'h5A));
        chk("load_flags", 32'({flag_z, flag_n, flag_c}), 32'(0));
        chk("load_no_done", 32'(n_done), 32'(0));

        // add with zero result and carry out
        run_op(3'b100, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

        // cmp leaves acc alone, flags come from sum_in
        acc_load = 1'b1; acc_load_val = 8'h10;
        tick();
        acc_load = 1'b0;
        model_acc = 8'h10;
        chk("load_acc2", 32'(acc), 32'(8'h10));
        run_op(3'b111, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0);

        // shift then and
        run_op(3'b110, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0);
        run_op(3'b000, 8'h81, 8'h00, 1'b1, 1'b1, 1'b0);

        // more patterns; the sub is issued with a simultaneous acc_load that must be dropped
        run_op(3'b101, 8'h7F, 8'h7F, 1'b0, 1'b1, 1'b1);
        run_op(3'b011, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0);
        run_op(3'b111, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0);

        // start held high, op toggling: accepts every S+2 cycles
        result = 8'h33; sum_in = 8'h00; carry_in = 1'b1; shift_co = 1'b0;
        exp_hold = op_hold;
        start = 1'b1; op = 3'b100;
        d0 = n_done;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i % int'(S + 2) == 0) begin
                exp_t e;
                exp_hold = op;
                e = model(op, result, sum_in, carry_in, shift_co, model_acc);
                sb.push_back(e);
                model_acc = e.acc;
            end
            chk("stream_op_hold", 32'(op_hold), 32'(exp_hold));
            nxt_op = (op == 3'b100) ? 3'b011 : 3'b100;
            op = nxt_op;
            acc_load = (i == 1);
            acc_load_val = 8'hEE;
            if (i == 14) start = 1'b0;
        end
        acc_load = 1'b0;
        chk("stream_dones", 32'(n_done - d0), 32'(3));
        chk("stream_acc", 32'(acc), 32'(model_acc));
        tick();

        // Reset in the second SETTLE cycle aborts the operation
        op = 3'b100; result = 8'h55; carry_in = 1'b0; start = 1'b1;
        d0 = n_done;
        tick();
        start = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("abort_acc", 32'(acc), 32'(0));
        chk("abort_op_hold", 32'(op_hold), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_flags", 32'({flag_z, flag_n, flag_c}), 32'(0));
        model_acc = 8'h00;
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("abort_no_done", 32'(n_done - d0), 32'(0));

        // Fresh operation after the abort
        run_op(3'b010, 8'h0F, 8'h00, 1'b1, 1'b1, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
